// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Round-robin arbiter and access controller sitting in front of the single
//   data BRAM. Port 0 is the core load/store unit and port 1 is the
//   debug/program loader. Byte-addressed RV32 loads/stores (byte, half, word)
//   become word-indexed BRAM accesses with byte write enables. Read data is
//   lane-aligned and sign/zero-extended one cycle after acceptance.
//   Misaligned, out-of-range and illegal-size requests are accepted but never
//   issued; they come back as error responses.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   pN_req_valid/ready       request handshake (ready is combinational grant)
//   pN_req_we/size/unsigned  access kind: store flag, size (0 B, 1 H, 2 W),
//                            zero-extend flag for loads
//   pN_req_addr/wdata        byte address, right-justified store data
//   pN_resp_valid/err/rdata  one-cycle response pulse, error flag,
//                            formatted load data (0 for stores and errors)
//   bram_w_enable            byte write enables
//   bram_r_addr/bram_w_addr  word index of the granted request
//   bram_w_data              lane-replicated store data
//   bram_row_addr            byte address of the granted request (trace)
//   bram_r_data              BRAM read data, one cycle after the address
//   conflict_cnt             saturating count of cycles with both ports valid
module dmem_arbiter #(
  parameter int MEM_WORDS = 32768,
  parameter int IDX_W     = 15
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  input  logic             p0_req_we,
  input  logic [1:0]       p0_req_size,
  input  logic             p0_req_unsigned,
  input  logic [31:0]      p0_req_addr,
  input  logic [31:0]      p0_req_wdata,
  output logic             p0_resp_valid,
  output logic             p0_resp_err,
  output logic [31:0]      p0_resp_rdata,

  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  input  logic             p1_req_we,
  input  logic [1:0]       p1_req_size,
  input  logic             p1_req_unsigned,
  input  logic [31:0]      p1_req_addr,
  input  logic [31:0]      p1_req_wdata,
  output logic             p1_resp_valid,
  output logic             p1_resp_err,
  output logic [31:0]      p1_resp_rdata,

  output logic [3:0]       bram_w_enable,
  output logic [IDX_W-1:0] bram_r_addr,
  output logic [IDX_W-1:0] bram_w_addr,
  output logic [31:0]      bram_w_data,
  output logic [31:0]      bram_row_addr,
  input  logic [31:0]      bram_r_data,

  output logic [31:0]      conflict_cnt
);

  // First byte address past the end of memory; 34 bits so it cannot wrap.
  localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;

  logic        prio;
  logic        both_valid;
  logic        grant_any;
  logic        grant_port;

  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_uns;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [1:0]  lane;

  logic        misaligned;
  logic        out_of_range;
  logic        illegal_size;
  logic        req_err;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;

  logic        rsp_valid;
  logic        rsp_port;
  logic [1:0]  rsp_lane;
  logic [1:0]  rsp_size;
  logic        rsp_uns;
  logic        rsp_we;
  logic        rsp_err;

  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] resp_data;

  // Arbitration: a lone requester always wins; on a conflict prio decides.
  assign both_valid   = p0_req_valid && p1_req_valid;
  assign grant_any    = (p0_req_valid || p1_req_valid) && !rst;
  assign grant_port   = both_valid ? prio : p1_req_valid;
  assign p0_req_ready = grant_any && !grant_port;
  assign p1_req_ready = grant_any && grant_port;

  assign sel_we    = grant_port ? p1_req_we       : p0_req_we;
  assign sel_size  = grant_port ? p1_req_size     : p0_req_size;
  assign sel_uns   = grant_port ? p1_req_unsigned : p0_req_unsigned;
  assign sel_addr  = grant_port ? p1_req_addr     : p0_req_addr;
  assign sel_wdata = grant_port ? p1_req_wdata    : p0_req_wdata;
  assign lane      = sel_addr[1:0];

  assign misaligned   = ((sel_size == 2'd1) && sel_addr[0]) ||
                        ((sel_size == 2'd2) && (sel_addr[1:0] != 2'b00));
  assign out_of_range = {2'b00, sel_addr} >= ADDR_LIMIT;
  assign illegal_size = (sel_size == 2'd3);
  assign req_err      = misaligned || out_of_range || illegal_size;

  // Store data is replicated across lanes so the enables alone pick the bytes.
  always_comb begin
    lane_mask  = 4'b1111;
    lane_wdata = sel_wdata;
    case (sel_size)
      2'd0: begin
        lane_mask  = 4'b0001 << lane;
        lane_wdata = {4{sel_wdata[7:0]}};
      end
      2'd1: begin
        lane_mask  = 4'b0011 << lane;
        lane_wdata = {2{sel_wdata[15:0]}};
      end
      default: begin
        lane_mask  = 4'b1111;
        lane_wdata = sel_wdata;
      end
    endcase
  end

  // grant_any already includes !rst, which suppresses writes during reset.
  assign bram_w_enable = (grant_any && sel_we && !req_err) ? lane_mask : 4'b0000;
  assign bram_w_data   = lane_wdata;
  assign bram_r_addr   = sel_addr[IDX_W+1:2];
  assign bram_w_addr   = sel_addr[IDX_W+1:2];
  assign bram_row_addr = sel_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      prio         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_port     <= 1'b0;
      rsp_lane     <= 2'b00;
      rsp_size     <= 2'b00;
      rsp_uns      <= 1'b0;
      rsp_we       <= 1'b0;
      rsp_err      <= 1'b0;
      conflict_cnt <= 32'h0;
    end else begin
      if (grant_any) begin
        prio <= !grant_port;
      end
      rsp_valid <= grant_any;
      rsp_port  <= grant_port;
      rsp_lane  <= lane;
      rsp_size  <= sel_size;
      rsp_uns   <= sel_uns;
      rsp_we    <= sel_we;
      rsp_err   <= req_err;
      if (both_valid && (conflict_cnt != 32'hFFFF_FFFF)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
    end
  end

  // Response formatting: shift the addressed lane down to bit 0, then extend.
  assign shifted = bram_r_data >> {rsp_lane, 3'b000};

  always_comb begin
    load_data = bram_r_data;
    case (rsp_size)
      2'd0: load_data = rsp_uns ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      2'd1: load_data = rsp_uns ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = bram_r_data;
    endcase
  end

  assign resp_data = (rsp_we || rsp_err) ? 32'h0 : load_data;

  assign p0_resp_valid = rsp_valid && !rsp_port;
  assign p1_resp_valid = rsp_valid && rsp_port;
  assign p0_resp_err   = p0_resp_valid && rsp_err;
  assign p1_resp_err   = p1_resp_valid && rsp_err;
  assign p0_resp_rdata = p0_resp_valid ? resp_data : 32'h0;
  assign p1_resp_rdata = p1_resp_valid ? resp_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: table-driven single-port vectors plus hand
// sequences for reset, round-robin and single-requester streaming. Responses
// are checked through a queue of expected results pushed on each accept.
module tb_dmem_arbiter;

  localparam int MEM_WORDS = 32768;
  localparam int IDX_W     = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic             p0_req_valid, p0_req_ready, p0_req_we, p0_req_unsigned;
  logic [1:0]       p0_req_size;
  logic [31:0]      p0_req_addr, p0_req_wdata;
  logic             p0_resp_valid, p0_resp_err;
  logic [31:0]      p0_resp_rdata;
  logic             p1_req_valid, p1_req_ready, p1_req_we, p1_req_unsigned;
  logic [1:0]       p1_req_size;
  logic [31:0]      p1_req_addr, p1_req_wdata;
  logic             p1_resp_valid, p1_resp_err;
  logic [31:0]      p1_resp_rdata;
  logic [3:0]       bram_w_enable;
  logic [IDX_W-1:0] bram_r_addr, bram_w_addr;
  logic [31:0]      bram_w_data, bram_row_addr, bram_r_data;
  logic [31:0]      conflict_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_we(p0_req_we), .p0_req_size(p0_req_size),
    .p0_req_unsigned(p0_req_unsigned), .p0_req_addr(p0_req_addr),
    .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
    .p0_resp_err(p0_resp_err), .p0_resp_rdata(p0_resp_rdata),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_we(p1_req_we), .p1_req_size(p1_req_size),
    .p1_req_unsigned(p1_req_unsigned), .p1_req_addr(p1_req_addr),
    .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
    .p1_resp_err(p1_resp_err), .p1_resp_rdata(p1_resp_rdata),
    .bram_w_enable(bram_w_enable), .bram_r_addr(bram_r_addr),
    .bram_w_addr(bram_w_addr), .bram_w_data(bram_w_data),
    .bram_row_addr(bram_row_addr), .bram_r_data(bram_r_data),
    .conflict_cnt(conflict_cnt)
  );

  // BRAM: byte-enabled write, registered read.
  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bram_w_enable[b]) mem[bram_w_addr][8*b +: 8] <= bram_w_data[8*b +: 8];
    end
    bram_r_data <= mem[bram_r_addr];
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sbq[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          resp_cnt [2];
  logic        exp_err [2];
  logic [31:0] exp_rd  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] exp_wen, input logic [31:0] exp_wdata,
                         input logic exp_err_i, input logic [31:0] exp_rdata);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_wen = exp_wen; v.exp_wdata = exp_wdata;
    v.exp_err = exp_err_i; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  // Called once per cycle at the falling edge: check the response due this
  // cycle, then record anything being accepted in it.
  task automatic mon_step();
    sb_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.port == 1'b0) begin
        chk("p0_resp_valid", {31'h0, p0_resp_valid}, 32'h1);
        chk("p1_resp_quiet", {31'h0, p1_resp_valid}, 32'h0);
        chk("p0_resp_err",   {31'h0, p0_resp_err}, {31'h0, e.err});
        chk("p0_resp_rdata", p0_resp_rdata, e.rdata);
        if (p0_resp_valid) resp_cnt[0]++;
      end else begin
        chk("p1_resp_valid", {31'h0, p1_resp_valid}, 32'h1);
        chk("p0_resp_quiet", {31'h0, p0_resp_valid}, 32'h0);
        chk("p1_resp_err",   {31'h0, p1_resp_err}, {31'h0, e.err});
        chk("p1_resp_rdata", p1_resp_rdata, e.rdata);
        if (p1_resp_valid) resp_cnt[1]++;
      end
    end else begin
      chk("resp_idle", {30'h0, p0_resp_valid, p1_resp_valid}, 32'h0);
    end
    if (p0_req_ready && p1_req_ready) begin
      chk("single_grant", {30'h0, p0_req_ready, p1_req_ready}, 32'h0);
    end
    if (p0_req_valid && p0_req_ready) begin
      e.port = 1'b0; e.err = exp_err[0]; e.rdata = exp_rd[0];
      sbq.push_back(e);
    end
    if (p1_req_valid && p1_req_ready) begin
      e.port = 1'b1; e.err = exp_err[1]; e.rdata = exp_rd[1];
      sbq.push_back(e);
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
    mon_step();
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic valid, input logic we,
                         input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic e_err, input logic [31:0] e_rd);
    if (p == 0) begin
      p0_req_valid = valid; p0_req_we = we; p0_req_size = size;
      p0_req_unsigned = uns; p0_req_addr = addr; p0_req_wdata = wdata;
    end else begin
      p1_req_valid = valid; p1_req_we = we; p1_req_size = size;
      p1_req_unsigned = uns; p1_req_addr = addr; p1_req_wdata = wdata;
    end
    exp_err[p] = e_err;
    exp_rd[p]  = e_rd;
  endtask

  logic [31:0] single_addr [4];
  logic [31:0] single_data [4];
  int          rc0, rc1;

  initial begin
    resp_cnt[0] = 0;
    resp_cnt[1] = 0;

    // vectors on port 0: we size uns addr wdata | wen wdata err rdata
    add_vec(1, 2, 0, 32'h100,   32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0, 32'h0);
    add_vec(1, 0, 0, 32'h101,   32'h1234565A, 4'h2, 32'h5A5A5A5A, 0, 32'h0);
    add_vec(0, 0, 0, 32'h101,   32'h0,        4'h0, 32'h0,        0, 32'h0000005A);
    add_vec(0, 2, 0, 32'h100,   32'h0,        4'h0, 32'h0,        0, 32'hDEAD5AEF);
    add_vec(1, 2, 0, 32'h200,   32'h8081FF7F, 4'hF, 32'h8081FF7F, 0, 32'h0);
    add_vec(0, 1, 0, 32'h202,   32'h0,        4'h0, 32'h0,        0, 32'hFFFF8081);
    add_vec(0, 1, 1, 32'h202,   32'h0,        4'h0, 32'h0,        0, 32'h00008081);
    add_vec(0, 0, 0, 32'h201,   32'h0,        4'h0, 32'h0,        0, 32'hFFFFFFFF);
    add_vec(0, 0, 1, 32'h200,   32'h0,        4'h0, 32'h0,        0, 32'h0000007F);
    add_vec(0, 1, 0, 32'h200,   32'h0,        4'h0, 32'h0,        0, 32'hFFFFFF7F);
    add_vec(1, 2, 0, 32'h204,   32'h00000000, 4'hF, 32'h00000000, 0, 32'h0);
    add_vec(1, 1, 0, 32'h206,   32'h0000BEEF, 4'hC, 32'hBEEFBEEF, 0, 32'h0);
    add_vec(0, 2, 0, 32'h204,   32'h0,        4'h0, 32'h0,        0, 32'hBEEF0000);
    add_vec(0, 1, 0, 32'h206,   32'h0,        4'h0, 32'h0,        0, 32'hFFFFBEEF);
    add_vec(0, 0, 1, 32'h207,   32'h0,        4'h0, 32'h0,        0, 32'h000000BE);
    add_vec(0, 2, 0, 32'h103,   32'h0,        4'h0, 32'h0,        1, 32'h0);
    add_vec(1, 1, 0, 32'h101,   32'h00001234, 4'h0, 32'h0,        1, 32'h0);
    add_vec(0, 2, 0, 32'h100,   32'h0,        4'h0, 32'h0,        0, 32'hDEAD5AEF);
    add_vec(0, 2, 0, 32'h20000, 32'h0,        4'h0, 32'h0,        1, 32'h0);
    add_vec(1, 2, 0, 32'h1FFFC, 32'h13579BDF, 4'hF, 32'h13579BDF, 0, 32'h0);
    add_vec(0, 2, 0, 32'h1FFFC, 32'h0,        4'h0, 32'h0,        0, 32'h13579BDF);
    add_vec(0, 3, 0, 32'h100,   32'h0,        4'h0, 32'h0,        1, 32'h0);
    add_vec(1, 3, 0, 32'h100,   32'hFFFFFFFF, 4'h0, 32'h0,        1, 32'h0);
    add_vec(1, 0, 0, 32'h103,   32'h000000A5, 4'h8, 32'hA5A5A5A5, 0, 32'h0);
    add_vec(0, 2, 0, 32'h100,   32'h0,        4'h0, 32'h0,        0, 32'hA5AD5AEF);
    add_vec(0, 0, 0, 32'h102,   32'h0,        4'h0, 32'h0,        0, 32'hFFFFFFAD);
    add_vec(1, 2, 0, 32'h302,   32'h55555555, 4'h0, 32'h0,        1, 32'h0);
    add_vec(0, 2, 0, 32'h400,   32'h0,        4'h0, 32'h0,        0, 32'h11111111);

    // Reset with both ports requesting.
    rst = 1'b1;
    set_req(0, 1, 1, 2, 0, 32'h400, 32'h11111111, 0, 32'h0);
    set_req(1, 1, 0, 2, 0, 32'h100, 32'h0,        0, 32'h0);
    repeat (2) begin
      to_negedge();
      chk("rst_ready", {30'h0, p0_req_ready, p1_req_ready}, 32'h0);
      chk("rst_wen",   {28'h0, bram_w_enable}, 32'h0);
      to_drive();
    end
    rst = 1'b0;
    to_negedge();
    chk("first_grant", {30'h0, p0_req_ready, p1_req_ready}, 32'h2);
    chk("rst_conflict_cnt", conflict_cnt, 32'h0);
    to_drive();
    set_req(0, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);
    set_req(1, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);

    // Table vectors, one per cycle on port 0.
    foreach (vecs[i]) begin
      set_req(0, 1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr,
              vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
      to_negedge();
      chk("vec_ready", {31'h0, p0_req_ready}, 32'h1);
      chk("vec_wen",   {28'h0, bram_w_enable}, {28'h0, vecs[i].exp_wen});
      if (vecs[i].exp_wen != 4'h0) chk("vec_wdata", bram_w_data, vecs[i].exp_wdata);
      if (!vecs[i].exp_err) begin
        chk("vec_row_addr", bram_row_addr, vecs[i].addr);
        chk("vec_w_addr", {17'h0, bram_w_addr}, {17'h0, vecs[i].addr[16:2]});
        chk("vec_r_addr", {17'h0, bram_r_addr}, {17'h0, vecs[i].addr[16:2]});
      end
      to_drive();
    end
    set_req(0, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);

    // Reset mid-operation: a pending load still answers, a store under reset
    // is suppressed.
    to_negedge();
    to_drive();
    set_req(0, 1, 0, 2, 0, 32'h100, 32'h0, 0, 32'hA5AD5AEF);
    to_negedge();
    to_drive();
    rst = 1'b1;
    set_req(0, 1, 1, 2, 0, 32'h100, 32'hFFFFFFFF, 0, 32'h0);
    set_req(1, 1, 0, 2, 0, 32'h200, 32'h0,        0, 32'h0);
    repeat (2) begin
      to_negedge();
      chk("midrst_ready", {30'h0, p0_req_ready, p1_req_ready}, 32'h0);
      chk("midrst_wen",   {28'h0, bram_w_enable}, 32'h0);
      to_drive();
    end
    rst = 1'b0;
    set_req(0, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);
    set_req(1, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);
    to_negedge();
    chk("midrst_conflict_cnt", conflict_cnt, 32'h0);
    to_drive();

    // Round-robin: both ports valid for 6 cycles.
    rc0 = resp_cnt[0];
    rc1 = resp_cnt[1];
    set_req(0, 1, 0, 2, 0, 32'h100, 32'h0, 0, 32'hA5AD5AEF);
    set_req(1, 1, 0, 2, 0, 32'h200, 32'h0, 0, 32'h8081FF7F);
    for (int i = 0; i < 6; i++) begin
      to_negedge();
      chk("rr_grant", {30'h0, p0_req_ready, p1_req_ready},
          (i % 2 == 0) ? 32'h2 : 32'h1);
      to_drive();
    end
    set_req(0, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);
    set_req(1, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);
    to_negedge();
    chk("rr_conflict_cnt", conflict_cnt, 32'd6);
    chk("rr_p0_resps", resp_cnt[0] - rc0, 32'd3);
    chk("rr_p1_resps", resp_cnt[1] - rc1, 32'd3);
    to_drive();

    // Single requester on port 1, streaming back-to-back loads.
    single_addr[0] = 32'h100;   single_data[0] = 32'hA5AD5AEF;
    single_addr[1] = 32'h200;   single_data[1] = 32'h8081FF7F;
    single_addr[2] = 32'h204;   single_data[2] = 32'hBEEF0000;
    single_addr[3] = 32'h1FFFC; single_data[3] = 32'h13579BDF;
    rc1 = resp_cnt[1];
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1, 0, 2, 0, single_addr[i], 32'h0, 0, single_data[i]);
      to_negedge();
      chk("single_grant_p1", {30'h0, p0_req_ready, p1_req_ready}, 32'h1);
      to_drive();
    end
    set_req(1, 0, 0, 2, 0, 32'h0, 32'h0, 0, 32'h0);
    repeat (2) begin
      to_negedge();
      to_drive();
    end
    chk("single_p1_resps", resp_cnt[1] - rc1, 32'd4);
    chk("single_conflict_cnt", conflict_cnt, 32'd6);
    chk("sb_drained", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access controller in front of the single data `bram`. It shares the memory between the core load/store unit (port 0) and the debug/program loader (port 1) using round-robin arbitration. It converts byte-addressed RV32 loads and stores (byte, half, word) into word-indexed BRAM accesses with byte write enables, and aligns and sign-extends returned read data. It also flags misaligned and out-of-range accesses instead of issuing them.

## Interface
- MEM_WORDS, 32768: BRAM depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-1.
- IDX_W, 15: word index width, equal to clog2(MEM_WORDS).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- pN_req_valid  in  1  request valid on port N (N = 0, 1).
- pN_req_ready  out  1  request accepted this cycle; a transfer occurs when valid && ready.
- pN_req_we  in  1  1 = store, 0 = load.
- pN_req_size  in  2  access size: 0 = byte, 1 = half, 2 = word; the value 3 is illegal.
- pN_req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
- pN_req_addr  in  32  byte address.
- pN_req_wdata  in  32  store data, right-justified.
- pN_resp_valid  out  1  one-cycle response pulse.
- pN_resp_err  out  1  access was misaligned, out of range or of illegal size; qualified by resp_valid.
- pN_resp_rdata  out  32  formatted load data; 0 for stores and errors.
- bram_w_enable  out  4  byte write enables to the BRAM.
- bram_r_addr  out  IDX_W  read word index.
- bram_w_addr  out  IDX_W  write word index.
- bram_w_data  out  32  lane-aligned store data.
- bram_row_addr  out  32  byte address of the granted request, used for trace.
- bram_r_data  in  32  BRAM read data, valid one cycle after the address is presented.
- conflict_cnt  out  32  saturating count of cycles in which both ports request.

## Operation
**Arbitration**
- A 1-bit register `prio` holds the favoured port; it resets to 0.
- When only one port is valid, that port is granted.
- When both ports are valid, port `prio` is granted.
- After any grant, `prio` becomes the non-granted port index.
- pN_req_ready is combinational and is asserted only for the granted port.
- Both ready signals are 0 while rst = 1.

**Legality check** (combinational, on the granted request)
- Misaligned: size = 1 with addr[0] = 1, or size = 2 with addr[1:0] != 0.
- Out of range: addr >= 4*MEM_WORDS.
- Illegal: size = 3.
- A request failing any check is still accepted (ready = 1). It issues no BRAM write (w_enable = 0) and responds with err = 1 and rdata = 0.

**Legal accesses**
- r_addr = w_addr = addr[IDX_W+1:2]; row_addr = addr.
- Store byte (SB): w_enable = 4'b0001 << addr[1:0]; w_data = {4{wdata[7:0]}}.
- Store half (SH): w_enable = 4'b0011 << addr[1:0]; w_data = {2{wdata[15:0]}}.
- Store word (SW): w_enable = 4'b1111; w_data = wdata.
- Loads drive w_enable = 0.
- When no request is granted, w_enable = 0 and the address outputs are don't-care.

**Response pipeline**
- On accept, one register stage captures: valid, port id, addr[1:0], size, unsigned, we and err.
- The next cycle, the selected port's resp_valid = 1.
- Loads use the byte or half at lane offset addr[1:0] of bram_r_data, sign- or zero-extended to 32 bits.
- Stores respond with rdata = 0, err = 0.

**Conflict counter**
- conflict_cnt increments in each cycle where p0_req_valid && p1_req_valid.
- It saturates at 0xFFFFFFFF.

## Timing
- Throughput: one accepted request per cycle in total across both ports.
- Latency: a request accepted in cycle N has its BRAM write take effect at the edge ending cycle N. Its response is valid throughout cycle N+1 only.
- There is no response backpressure; requesters must sample resp in cycle N+1.
- Back-to-back store then load to the same word: the load accepted in N+1 returns the new data in N+2.
- A load accepted in the same cycle as a store cannot occur, since only one grant is made per cycle.
- Reset values: prio = 0, response valid register = 0, all resp_valid = 0, resp_err = 0, resp_rdata = 0, conflict_cnt = 0.
- Reset asserted mid-operation:
  - A response pending from the previous cycle is dropped; resp_valid = 0 in the cycle after rst is sampled high.
  - A BRAM write presented in the same cycle as rst is suppressed (w_enable = 0 while rst = 1).
- Request inputs must be held stable while valid && !ready. The arbiter does not require this for correctness, but requesters rely on it.

## Test plan
- **Reset**
  - Stimulus: assert rst for 2 cycles with both ports valid.
  - Required: ready = 0, w_enable = 0; after release conflict_cnt = 0 and p0 is granted first.
- **Store/load byte round trip**
  - Stimulus: on p0, SW 0xDEADBEEF to 0x100, then SB 0x5A to 0x101, then LB from 0x101.
  - Required: SB drives w_enable = 0010 and w_data = 0x5A5A5A5A; the LB response in the following cycle is rdata = 0x0000005A.
  - Then LW from 0x100 returns 0xDEAD5AEF.
- **Sign extension**
  - Stimulus: memory word at 0x200 = 0x8081FF7F.
  - Required: LH 0x202 → 0xFFFF8081; LHU 0x202 → 0x00008081; LB 0x201 → 0xFFFFFFFF; LBU 0x200 → 0x0000007F.
- **Errors**
  - LW 0x103 → err = 1, no write.
  - SH 0x101 → err = 1, w_enable = 0, memory unchanged.
  - LW 0x20000 → err = 1.
  - size = 3 → err = 1.
- **Round-robin**
  - Stimulus: both ports valid for 6 cycles.
  - Required: grants alternate p0, p1, p0, p1, p0, p1; each port receives 3 responses on the correct port; conflict_cnt = 6.
- **Single requester**
  - Stimulus: p1 valid alone for 4 cycles with prio = 0.
  - Required: p1 is granted every cycle, and the responses are pipelined back-to-back.
